uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer, a mid-bit
// sampling FSM and registered one-cycle strobes for good / bad frames.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   uart_rxd   asynchronous serial line (idle high, LSB first)
//   rx_de      one-cycle strobe, rx_data valid in the same cycle
//   rx_data    last correctly framed byte
//   frame_err  one-cycle strobe, stop bit sampled low
//   rx_busy    high while a frame is in progress
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       rx_de,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = BAUD_DIV / 2;
  localparam int unsigned CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_d;
  logic             de_d, ferr_d, busy_d;

  logic             rxd_meta, rxd_s, rxd_prev;
  logic             fall;

  // Two-flop synchronizer plus one delay stage for edge detection; all idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  // Only a genuine 1->0 transition starts a frame, so a held-low break is ignored.
  assign fall = rxd_prev & ~rxd_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_de     <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data   <= data_d;
      rx_de     <= de_d;
      frame_err <= ferr_d;
      rx_busy   <= busy_d;
    end
  end

  // Next-state and output logic; the counter restarts from zero on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = rx_data;
    de_d    = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        // Re-check the start bit at its middle to reject short glitches.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxd_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxd_s;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s) begin
            data_d = shift_q;
            de_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLK_FREQ=16, BAUD=1 (16 clocks/bit).
// Expected bytes are queued as frames are driven; received bytes are logged by a
// monitor and compared against the queue after each scenario.
module tb_uart_rx;

  localparam int unsigned BIT_T = 16;

  logic       clk;
  logic       rst_n;
  logic       uart_rxd;
  logic       rx_de;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .rx_de     (rx_de),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: logs every strobe observed away from the active edge.
  logic [7:0] got_data[$];
  int         got_cyc[$];
  int         cyc      = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_de) begin
      got_data.push_back(rx_data);
      got_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_de && frame_err) both_cnt <= both_cnt + 1;
  end

  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         n_tests  = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    uart_rxd = b;
    repeat (n) @(negedge clk);
  endtask

  // Edge k (1..9) is displaced by +jit for odd k and -jit for even k.
  function automatic int edge_off(input int k, input int jit);
    if (k == 0 || k == 10) return 0;
    return (k % 2 == 1) ? jit : -jit;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop, input int jit);
    logic v;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = stop;
      else             v = d[k-1];
      send_bit(v, int'(BIT_T) + edge_off(k + 1, jit) - edge_off(k, jit));
    end
    if (stop) exp_q.push_back(d);
    else      exp_ferr++;
  endtask

  // Bounded wait for the receiver to return to idle.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (rx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_low"}, 32'(rx_busy), 32'(0));
  endtask

  // Scoreboard pop: received byte count and values against the expected queue.
  task automatic check_frames(input string tag);
    logic [7:0] e;
    logic [7:0] g;
    check({tag, "_count"}, 32'(got_data.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_data.size() > 0) begin
      e = exp_q.pop_front();
      g = got_data.pop_front();
      void'(got_cyc.pop_front());
      check({tag, "_data"}, 32'(g), 32'(e));
    end
    exp_q.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  initial begin
    logic [7:0] held;
    uart_rxd = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_de", 32'(rx_de), 32'(0));
    check("reset_frame_err", 32'(frame_err), 32'(0));
    check("reset_rx_busy", 32'(rx_busy), 32'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Ideal 0x55; busy must be high mid-frame.
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        repeat (40) @(negedge clk);
        check("t55_busy_mid", 32'(rx_busy), 32'(1));
        check("t55_data_hidden", 32'(rx_data), 32'h00);
      end
    join
    send_bit(1'b1, BIT_T);
    wait_idle("t55");
    check_frames("t55");
    check("t55_ferr", 32'(ferr_cnt), 32'(exp_ferr));

    // Back-to-back frames with no idle bits between them.
    send_frame(8'hA3, 1'b1, 0);
    send_frame(8'h0F, 1'b1, 0);
    send_bit(1'b1, BIT_T);
    wait_idle("b2b");
    check("b2b_pulses", 32'(got_cyc.size()), 32'(2));
    if (got_cyc.size() >= 2)
      check("b2b_spacing", 32'(got_cyc[1] - got_cyc[0]), 32'(BIT_T * 10));
    check_frames("b2b");

    // Four-clock low glitch on an idle line is rejected.
    send_bit(1'b0, 4);
    send_bit(1'b1, 3 * BIT_T);
    check("glitch_busy", 32'(rx_busy), 32'(0));
    check("glitch_no_de", 32'(got_data.size()), 32'(0));
    check("glitch_no_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    send_frame(8'h3C, 1'b1, 0);
    send_bit(1'b1, BIT_T);
    wait_idle("g3c");
    check_frames("g3c");

    // Bad stop bit, then a 40-bit break, then a good 0x7E.
    held = 8'h3C;
    send_frame(8'h81, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      send_bit(1'b0, BIT_T);
      if (i % 8 == 0) check("break_rx_data_hold", 32'(rx_data), 32'(held));
    end
    check("break_idle", 32'(rx_busy), 32'(0));
    check("break_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    check("break_no_de", 32'(got_data.size()), 32'(0));
    send_bit(1'b1, 2 * BIT_T);
    send_frame(8'h7E, 1'b1, 0);
    send_bit(1'b1, BIT_T);
    wait_idle("t7e");
    check_frames("t7e");
    check("t7e_ferr", 32'(ferr_cnt), 32'(exp_ferr));

    // Reset during bit 4 of a 0xFF frame; the tail must not produce a strobe.
    send_bit(1'b0, BIT_T);
    send_bit(1'b1, 4 * BIT_T + 8);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_busy", 32'(rx_busy), 32'(0));
    check("rst_mid_data", 32'(rx_data), 32'h00);
    rst_n = 1'b1;
    send_bit(1'b1, 8 + 5 * BIT_T);
    check("rst_no_de", 32'(got_data.size()), 32'(0));
    check("rst_no_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    check("rst_rx_data", 32'(rx_data), 32'h00);
    send_frame(8'hC6, 1'b1, 0);
    send_bit(1'b1, BIT_T);
    wait_idle("tc6");
    check_frames("tc6");

    // Edge timing jittered by +/-3 clocks.
    send_frame(8'h96, 1'b1, 3);
    send_bit(1'b1, 2 * BIT_T);
    wait_idle("t96");
    check_frames("t96");
    check("t96_ferr", 32'(ferr_cnt), 32'(exp_ferr));

    check("never_both", 32'(both_cnt), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
